// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle instruction sequencer. Fetches a word, checks
// the opcode, steps through execute / memory / write-back and retires one
// instruction at a time. Every fault is sticky until reset.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for run
// FETCH  | imem_req high until imem_ack; the word is captured into ir
// DECODE | one cycle opcode legality check
// EXEC   | one cycle; loads and stores go on to MEM
// MEM    | dmem_req high until dmem_ack
// WB     | retire, commit pc / instret, or trap on a misaligned target
// TRAP   | sticky fault; requests held low until reset
module core_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int RAM_WIDTH  = 31,
  parameter int FW_LENGTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] ir,
  output logic [DATA_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] alu_pc_next,
  input  logic                  alu_rf_we,
  input  logic                  alu_ram_we,
  output logic                  dmem_req,
  output logic                  dmem_we,
  input  logic                  dmem_ack,
  output logic                  rf_we,
  output logic                  retire,
  output logic [31:0]           instret,
  output logic                  trap
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  // The opcode and rd fields need at least 12 bits of instruction word.
  if (DATA_WIDTH < 12 || RAM_WIDTH < 1 || RAM_WIDTH > DATA_WIDTH || FW_LENGTH < 1) begin : g_param_check
    $error("core_sequencer: unsupported parameter combination");
  end

  logic [2:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic [31:0]           instret_q, instret_d;

  logic [6:0] opcode;
  logic       op_legal;
  logic       op_mem;
  logic       target_ok;

  assign opcode    = ir_q[6:0];
  assign target_ok = (alu_pc_next[1:0] == 2'b00);

  // Opcode classification for DECODE and EXEC.
  always_comb begin
    op_legal = 1'b0;
    op_mem   = 1'b0;
    case (opcode)
      7'b0110011, 7'b0010011, 7'b1100011, 7'b0110111,
      7'b0010111, 7'b1101111, 7'b1100111: op_legal = 1'b1;
      7'b0000011, 7'b0100011: begin
        op_legal = 1'b1;
        op_mem   = 1'b1;
      end
      default: op_legal = 1'b0;
    endcase
  end

  // Next-state and architectural register update.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    instret_d = instret_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = op_legal ? S_EXEC : S_TRAP;
      S_EXEC:   state_d = op_mem ? S_MEM : S_WB;
      S_MEM: begin
        if (dmem_ack) state_d = S_WB;
      end
      S_WB: begin
        if (!target_ok) begin
          state_d = S_TRAP;
        end else begin
          pc_d      = alu_pc_next;
          instret_d = instret_q + 32'd1;
          state_d   = run ? S_FETCH : S_IDLE;
        end
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      instret_q <= instret_d;
    end
  end

  // Requests and strobes come from the registered state, never from an ack.
  assign imem_req  = (state_q == S_FETCH);
  assign dmem_req  = (state_q == S_MEM);
  assign dmem_we   = (state_q == S_MEM) & alu_ram_we;
  assign retire    = (state_q == S_WB) & target_ok;
  assign rf_we     = retire & alu_rf_we & (ir_q[11:7] != 5'd0);
  assign trap      = (state_q == S_TRAP);
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Testbench for core_sequencer: directed instructions, expected retire/trap
// events queued by the stimulus and checked by an independent monitor.
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, run;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
  logic        alu_rf_we, alu_ram_we, rf_we, retire, trap;
  logic [31:0] imem_addr, imem_rdata, ir, pc, alu_pc_next, instret;

  core_sequencer #(.DATA_WIDTH(32), .RAM_WIDTH(31), .FW_LENGTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir(ir), .pc(pc), .alu_pc_next(alu_pc_next), .alu_rf_we(alu_rf_we), .alu_ram_we(alu_ram_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .retire(retire), .instret(instret), .trap(trap)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int imem_cnt = 0;
  int dmem_req_cnt = 0;
  int dmem_we_cnt  = 0;

  // kind 0 = retire, kind 1 = trap entry
  typedef struct {
    int          kind;
    int          cyc;
    logic        rf_we;
    logic [31:0] pc;
    logic [31:0] instret;
    logic [31:0] ir;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples on the falling edge and consumes scoreboard entries.
  initial begin
    exp_t e;
    exp_t pend;
    bit   pending = 0;
    logic trap_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (pending) begin
        check("pc_after_retire", pc, pend.pc);
        check("instret_after_retire", instret, pend.instret);
        pending = 0;
      end
      if (imem_req) imem_cnt++;
      if (dmem_req) dmem_req_cnt++;
      if (dmem_req && dmem_we) dmem_we_cnt++;
      if (retire) begin
        if (sb.size() == 0) begin
          check("unexpected_retire", {31'd0, retire}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("event_is_retire", e.kind, 0);
          check("retire_cycle", cyc, e.cyc);
          check("rf_we_at_retire", {31'd0, rf_we}, {31'd0, e.rf_we});
          check("ir_at_retire", ir, e.ir);
          pend    = e;
          pending = 1;
        end
      end else if (rf_we) begin
        check("rf_we_without_retire", {31'd0, rf_we}, 32'd0);
      end
      if (trap && !trap_prev) begin
        if (sb.size() == 0) begin
          check("unexpected_trap", {31'd0, trap}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("event_is_trap", e.kind, 1);
          check("trap_cycle", cyc, e.cyc);
          check("pc_at_trap", pc, e.pc);
          check("instret_at_trap", instret, e.instret);
          check("ir_at_trap", ir, e.ir);
          check("imem_req_in_trap", {31'd0, imem_req}, 32'd0);
        end
      end
      trap_prev = trap;
    end
  end

  // One instruction from IDLE. Called 1 ns after a rising edge.
  // id = imem ack delay, dd = dmem ack delay, lat = expected event cycle offset.
  task automatic do_instr(input logic [31:0] word, input logic [31:0] pc_next,
                          input logic rfw, input logic ramw, input int id, input int dd,
                          input logic mem, input logic spur_dmem, input int kind, input int lat,
                          input logic erfw, input logic [31:0] epc, input logic [31:0] einst);
    exp_t e;
    alu_pc_next  = pc_next;
    alu_rf_we    = rfw;
    alu_ram_we   = ramw;
    dmem_ack     = spur_dmem;
    dmem_req_cnt = 0;
    dmem_we_cnt  = 0;
    run          = 1'b1;
    e.kind    = kind;
    e.cyc     = cyc + lat;
    e.rf_we   = erfw;
    e.pc      = epc;
    e.instret = einst;
    e.ir      = word;
    sb.push_back(e);
    @(posedge clk) #1;
    run = 1'b0;
    repeat (id) @(posedge clk) #1;
    imem_ack   = 1'b1;
    imem_rdata = word;
    @(posedge clk) #1;
    imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk) #1;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    if (mem) begin
      @(posedge clk) #1;
      repeat (dd) @(posedge clk) #1;
      dmem_ack = 1'b1;
      @(posedge clk) #1;
    end
    dmem_ack = 1'b0;
    repeat (4) @(posedge clk) #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (2) @(posedge clk) #1;
    rst_n = 1'b1;
    @(posedge clk) #1;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    imem_rdata = 32'h0; alu_pc_next = 32'h0; alu_rf_we = 1'b0; alu_ram_we = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    check("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
    check("rst_retire", {31'd0, retire}, 32'd0);
    check("rst_trap", {31'd0, trap}, 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_ir", ir, 32'h0);
    check("rst_instret", instret, 32'h0);
    @(posedge clk) #1;
    rst_n = 1'b1;
    imem_cnt = 0;
    repeat (3) @(posedge clk) #1;
    check("idle_hold_no_fetch", imem_cnt, 0);

    // ADD x3: retire on cycle 4, rf_we, pc=4, instret=1
    do_instr(32'h0020_81B3, 32'h4, 1, 0, 0, 0, 0, 0, 0, 4, 1, 32'h4, 32'd1);
    check("add_no_dmem", dmem_req_cnt, 0);
    // Store, dmem ack 3 cycles late: 4 cycles of req+we, retire on cycle 8
    do_instr(32'h0020_A023, 32'h8, 0, 1, 0, 3, 1, 0, 0, 8, 0, 32'h8, 32'd2);
    check("store_dmem_req_cycles", dmem_req_cnt, 4);
    check("store_dmem_we_cycles", dmem_we_cnt, 4);
    // Load, imem ack 2 cycles late, dmem ack immediate
    do_instr(32'h0000_A183, 32'hC, 1, 0, 2, 0, 1, 0, 0, 7, 1, 32'hC, 32'd3);
    check("load_dmem_req_cycles", dmem_req_cnt, 1);
    check("load_dmem_we_cycles", dmem_we_cnt, 0);
    // ADDI x0 with alu_rf_we=1 and a stray dmem_ack held high: rf_we stays 0
    do_instr(32'h0000_0013, 32'h10, 1, 0, 0, 0, 0, 1, 0, 4, 0, 32'h10, 32'd4);
    check("stray_dmem_ack_no_req", dmem_req_cnt, 0);
    // LUI x1 with a high target: pc is taken unclamped
    do_instr(32'h1234_50B7, 32'hFFFF_FFFC, 1, 0, 0, 0, 0, 0, 0, 4, 1, 32'hFFFF_FFFC, 32'd5);

    // instret wrap
    force dut.instret_q = 32'hFFFF_FFFF;
    @(posedge clk) #1;
    release dut.instret_q;
    @(negedge clk);
    check("instret_preset", instret, 32'hFFFF_FFFF);
    @(posedge clk) #1;
    do_instr(32'h0020_81B3, 32'h100, 1, 0, 0, 0, 0, 0, 0, 4, 1, 32'h100, 32'd0);

    // JAL to a misaligned target: trap after WB, pc and instret unchanged
    do_instr(32'h0000_006F, 32'h6, 1, 0, 0, 0, 0, 0, 1, 5, 0, 32'h100, 32'd0);
    imem_cnt = 0;
    run = 1'b1;
    repeat (6) @(posedge clk) #1;
    run = 1'b0;
    check("trap_no_fetch", imem_cnt, 0);
    check("trap_sticky", {31'd0, trap}, 32'd1);

    // FENCE: illegal opcode traps right after DECODE
    reset_dut();
    check("reset_clears_trap", {31'd0, trap}, 32'd0);
    do_instr(32'h0000_000F, 32'h4, 1, 0, 0, 0, 0, 0, 1, 3, 0, 32'h0, 32'd0);

    // Reset during a MEM wait
    reset_dut();
    do_instr(32'h0020_81B3, 32'h4, 1, 0, 1, 0, 0, 0, 0, 5, 1, 32'h4, 32'd1);
    alu_ram_we = 1'b1;
    alu_pc_next = 32'h8;
    run = 1'b1;
    @(posedge clk) #1;
    run = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'h0020_A023;
    @(posedge clk) #1;
    imem_ack = 1'b0;
    repeat (3) @(posedge clk) #1;
    check("mem_wait_dmem_req", {31'd0, dmem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("reset_drops_dmem_req", {31'd0, dmem_req}, 32'd0);
    check("reset_drops_dmem_we", {31'd0, dmem_we}, 32'd0);
    check("reset_mid_mem_pc", pc, 32'h0);
    check("reset_mid_mem_instret", instret, 32'h0);
    @(posedge clk) #1;
    rst_n = 1'b1;
    run = 1'b1;
    @(posedge clk) #1;
    @(posedge clk) #1;
    run = 1'b0;
    check("restart_imem_req", {31'd0, imem_req}, 32'd1);
    check("restart_imem_addr", imem_addr, 32'h0);

    repeat (3) @(posedge clk) #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
